// File: rtl/dut_arb_pkg.sv
// Shared types and helpers for the dut_arbiter slice: FSM state enum and the
// width function used for tags, pointers and counters.
package dut_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    // Bit width needed to index n items; never narrower than one bit.
    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dut_arbiter_if.sv
// Clock/reset bundle for the arbiter slice. rst is asynchronous, active-high.
// The master side (bench or clock/reset generator) drives it; blocks use slave.
interface dut_arbiter_if;

    logic clk;
    logic rst;

    modport master (output clk, output rst);
    modport slave  (input  clk, input  rst);

endinterface

// File: rtl/dut_arb_tag_fifo.sv
// In-order tag FIFO recording which requester owns each in-flight request.
// A push and a pop in the same cycle are both honoured, even when full.
module dut_arb_tag_fifo
    import dut_arb_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int TAG_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [TAG_W-1:0] head_o
);

    localparam int PTR_W = tag_width(DEPTH);
    localparam int CNT_W = tag_width(DEPTH + 1);

    logic [TAG_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the head slot in the same cycle, so a full FIFO may still push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Next pointers and occupancy, wrapping modulo DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Tag storage write.
    // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= tag_i;
        end
    end

endmodule

// File: rtl/dut_arbiter.sv
// Round-robin arbiter sharing one downstream request/response channel among
// NUM_REQ requesters, with in-order response routing through a tag FIFO.
// Optional feature: define DUT_ARB_STATS_EN to add per-requester saturating
// grant counters on output grant_cnt_o.
module dut_arbiter
    import dut_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 16,
    parameter int MAX_OUT   = 3
) (
    dut_arbiter_if.slave                     clrst_if,
    input  logic [NUM_REQ-1:0]                up_req_valid_i,
    input  logic [NUM_REQ-1:0][DATA_SIZE-1:0] up_req_data_i,
    output logic [NUM_REQ-1:0]                up_req_ready_o,
    output logic [NUM_REQ-1:0]                up_resp_valid_o,
    output logic [DATA_SIZE-1:0]              up_resp_data_o,
    output logic                              dn_req_valid_o,
    output logic [DATA_SIZE-1:0]              dn_req_data_o,
    input  logic                              dn_req_ready_i,
    input  logic                              dn_resp_valid_i,
    input  logic [DATA_SIZE-1:0]              dn_resp_data_i,
    output logic                              err_o
`ifdef DUT_ARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]          grant_cnt_o
`endif
);

    localparam int TAG_W = tag_width(NUM_REQ);

    logic                   clk;
    logic                   rst;
    arb_state_e             state_q, state_d;
    logic [TAG_W-1:0]       ptr_q, ptr_d;
    logic [DATA_SIZE-1:0]   data_q, data_d;
    logic                   err_q, err_d;
    logic [2*NUM_REQ-1:0]   req_dbl;
    logic [NUM_REQ-1:0]     req_rot;
    logic                   win_found;
    int                     win_sum;
    logic [TAG_W-1:0]       win_idx;
    logic                   grant;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic [TAG_W-1:0]       fifo_head;

    assign clk = clrst_if.clk;
    assign rst = clrst_if.rst;

    // Round-robin search: rotate the request vector by ptr, take the first set bit.
    always_comb begin
        req_dbl   = {up_req_valid_i, up_req_valid_i};
        req_rot   = NUM_REQ'(req_dbl >> ptr_q);
        win_found = 1'b0;
        win_sum   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_found && req_rot[i]) begin
                win_found = 1'b1;
                win_sum   = int'(ptr_q) + i;
            end
        end
        if (win_sum >= NUM_REQ) begin
            win_sum = win_sum - NUM_REQ;
        end
        win_idx = TAG_W'(win_sum);
    end

    // FSM next state: grant in IDLE when a slot is free, present the request in HOLD.
    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        data_d         = data_q;
        grant          = 1'b0;
        dn_req_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                // rst gate keeps the combinational ready low while reset is held.
                if (!rst && win_found && !fifo_full) begin
                    grant   = 1'b1;
                    ptr_d   = (win_idx == TAG_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
                    data_d  = up_req_data_i[win_idx];
                    state_d = HOLD;
                end
            end
            HOLD: begin
                dn_req_valid_o = 1'b1;
                if (dn_req_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Single-cycle accept pulse to the winning requester.
    always_comb begin
        up_req_ready_o = '0;
        if (grant) begin
            up_req_ready_o[win_idx] = 1'b1;
        end
    end

    // Combinational response route to the owner of the head tag.
    always_comb begin
        up_resp_valid_o = '0;
        up_resp_data_o  = '0;
        if (fifo_pop) begin
            up_resp_valid_o[fifo_head] = 1'b1;
            up_resp_data_o             = dn_resp_data_i;
        end
    end

    assign fifo_pop      = dn_resp_valid_i && !fifo_empty;
    assign err_d         = err_q || (dn_resp_valid_i && fifo_empty);
    assign dn_req_data_o = data_q;
    assign err_o         = err_q;

    // State, pointer, latched payload and sticky error registers.
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    dut_arb_tag_fifo #(
        .DEPTH (MAX_OUT),
        .TAG_W (TAG_W)
    ) u_tag_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (grant),
        .tag_i   (win_idx),
        .pop_i   (fifo_pop),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

`ifdef DUT_ARB_STATS_EN
    logic [NUM_REQ-1:0][15:0] grant_cnt_q;

    // Per-requester saturating accept counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant && (win_idx == TAG_W'(i)) && (grant_cnt_q[i] != 16'hFFFF)) begin
                    grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign grant_cnt_o = grant_cnt_q;
`endif

endmodule

// File: doc/dut_arbiter.md
DUT_ARBITER -- requirements
Module: dut_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing dut_top.
REQ-002 Parameter DATA_SIZE, default 16: payload width, equal to dut_top DATA_SIZE.
REQ-003 Parameter MAX_OUT, default 3: maximum in-flight requests, equal to dut_top DEPTH.
REQ-004 Port clrst_if, interface, -: clock clrst_if.clk; reset clrst_if, asynchronous, active-high.
REQ-005 Port up_req_valid_i, in, NUM_REQ: per-requester request valid.
REQ-006 Port up_req_data_i, in, NUM_REQ x DATA_SIZE: per-requester request payload.
REQ-007 Port up_req_ready_o, out, NUM_REQ: per-requester accept, one-hot or zero.
REQ-008 Port up_resp_valid_o, out, NUM_REQ: routed response valid, one-hot or zero.
REQ-009 Port up_resp_data_o, out, DATA_SIZE: routed response payload, shared by all requesters.
REQ-010 Port dn_req_valid_o / dn_req_data_o / dn_req_ready_i, out/out/in, 1/DATA_SIZE/1: dut_top request channel.
REQ-011 Port dn_resp_valid_i / dn_resp_data_i, in, 1/DATA_SIZE: dut_top response channel, in order, no backpressure.
REQ-012 Port err_o, out, 1: sticky protocol error.

Function
REQ-013 The FSM SHALL have states IDLE and HOLD.
- IDLE: any valid requester and in-flight count < MAX_OUT -> latch round-robin winner, go to HOLD.
- HOLD: dn_req_valid_o=1 with latched data; on dn_req_valid_o & dn_req_ready_i -> IDLE.
REQ-014 Round-robin SHALL start searching at pointer ptr (reset 0); on each accept, ptr becomes winner+1 mod NUM_REQ.
REQ-015 The grant SHALL stay stable in HOLD; requester data is sampled once, in IDLE.
REQ-016 up_req_ready_o[winner] SHALL pulse for exactly the accept cycle.
- A requester SHALL hold valid/data until its ready pulse.
REQ-017 Minimum latency: valid seen in IDLE at cycle t -> dn_req_valid_o at t+1; back-to-back accept every 2 cycles.
REQ-018 On accept, winner ID SHALL be pushed into an in-order tag FIFO of depth MAX_OUT.
REQ-019 When the FIFO is full, the FSM SHALL stay in IDLE and issue no grant.
REQ-020 On dn_resp_valid_i, the block SHALL pop the head tag and drive up_resp_valid_o[tag]=1 and up_resp_data_o=dn_resp_data_i in the same cycle (combinational route).
REQ-021 A simultaneous push and pop SHALL leave the count unchanged.
- This holds when full: the pop frees space for the push in the same cycle.
REQ-022 If dn_resp_valid_i arrives with the FIFO empty, the block SHALL set err_o and drop the response.
- err_o clears only on reset.
REQ-023 Counter and pointer arithmetic SHALL wrap modulo depth/NUM_REQ, using $clog2 widths (minimum 1).

Reset
REQ-024 On reset, the block SHALL force:
- state IDLE, ptr 0, FIFO empty
- all valid/ready outputs 0, data outputs 0, err_o 0
REQ-025 Reset mid-HOLD SHALL abandon the grant; the requester retries after reset.

Configuration
REQ-026 With DUT_ARB_STATS_EN defined, the block SHALL add output grant_cnt_o, NUM_REQ x 16.
- One saturating counter per requester, incremented on each accept, reset to 0.
- Without the macro, neither the port nor the counters exist.

Structure
REQ-027 Package dut_arb_pkg SHALL hold the state enum (IDLE, HOLD) and the tag type width function.
REQ-028 The tag FIFO SHALL be sub-module dut_arb_tag_fifo (push, pop, full, empty, head).

Verification
REQ-029 Single request: requester 0 sends 0x000A -> dn_req_data_o=0x000A.
- Response 0x000A returns only on up_resp_valid_o=4'b0001.
REQ-030 Fairness: all 4 requesters valid continuously, 8 accepts.
- Grant order 0,1,2,3,0,1,2,3.
- Each up_req_ready_o is a single-cycle pulse.
REQ-031 Full: dut_top withholds responses and requester 2 sends 4 requests.
- Only 3 are accepted; the 4th is accepted the cycle after the first response.
- Responses route to requester 2 in order.
REQ-032 Mixed routing: requesters 1 and 3 interleave payloads 0x20..0x25.
- Each response reaches its originating requester, with data unchanged.
REQ-033 Spurious response: dn_resp_valid_i with no in-flight request.
- err_o=1 and no up_resp_valid_o bit set.
REQ-034 Reset in HOLD with DUT_ARB_STATS_EN defined.
- All outputs 0 and grant_cnt_o 0.
- The next request is granted normally.
